// File: rtl/tdm_demux_1to2.sv
// Receive-side 1:2 TDM demultiplexer: splits a sync-framed bit-serial stream into
// channel A (even slots) and channel B (odd slots) words, MSB first on the line.
module tdm_demux_1to2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    input  logic             sync,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             out_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int SLOTS = 2 * WIDTH;
    localparam int CNT_W = $clog2(SLOTS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] w_sh_a_nxt;
    logic [WIDTH-1:0] w_sh_b_nxt;
    logic [WIDTH-1:0] r_a_out;
    logic [WIDTH-1:0] r_b_out;
    logic [WIDTH-1:0] w_a_out_nxt;
    logic [WIDTH-1:0] w_b_out_nxt;
    logic             r_out_valid;
    logic             r_frame_err;
    logic             w_valid_nxt;
    logic             w_err_nxt;

    // NOTE: every signal gets a default before any branch, so no path leaves one
    // unassigned and no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_a_nxt  = r_sh_a;
        w_sh_b_nxt  = r_sh_b;
        w_a_out_nxt = r_a_out;
        w_b_out_nxt = r_b_out;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        if (din_en) begin
            if (sync) begin
                // Sync wins in any state; a frame in progress is abandoned.
                w_err_nxt   = (r_state == RECV);
                w_state_nxt = RECV;
                w_cnt_nxt   = CNT_W'(1);
                w_sh_a_nxt  = {{(WIDTH-1){1'b0}}, din};
                w_sh_b_nxt  = '0;
            end else if (r_state == RECV) begin
                if (!r_cnt[0]) begin
                    w_sh_a_nxt = {r_sh_a[WIDTH-2:0], din};
                end else begin
                    w_sh_b_nxt = {r_sh_b[WIDTH-2:0], din};
                end
                w_cnt_nxt = r_cnt + 1'b1;

                // The last slot is odd, so it completes B in the same edge.
                if (r_cnt == LAST_SLOT) begin
                    w_a_out_nxt = r_sh_a;
                    w_b_out_nxt = {r_sh_b[WIDTH-2:0], din};
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sh_a      <= w_sh_a_nxt;
            r_sh_b      <= w_sh_b_nxt;
            r_a_out     <= w_a_out_nxt;
            r_b_out     <= w_b_out_nxt;
            r_out_valid <= w_valid_nxt;
            r_frame_err <= w_err_nxt;
        end
    end

    assign a_out     = r_a_out;
    assign b_out     = r_b_out;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state == RECV);

endmodule
